// File: rtl/cgra_seq_pkg.sv
// ============================================================================
//  Module      : cgra_seq_pkg
//  Description : Shared types and constants for the CGRA host sequencer.
//                The DRAIN state exists only when CGRA_SEQ_HS_TIMEOUT_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cgra_seq_pkg;

    // Sequencer states (explicit 3-bit encoding)
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_LOAD   = 3'd2,
        S_HS     = 3'd3,
        S_STREAM = 3'd4
`ifdef CGRA_SEQ_HS_TIMEOUT_EN
        ,
        S_DRAIN  = 3'd5
`endif
    } seq_state_t;

    // Header field positions, in units of the entry-count field width
    localparam int HDR_CFG_FIELD = 0;
    localparam int HDR_INB_FIELD = 1;

    // Handshake timeout: cycles spent in HS before giving up
    localparam int HS_TIMEOUT = 1024;
    localparam int HS_TO_W    = 10;

endpackage

`default_nettype wire

// File: rtl/cgra_load_buffer.sv
// ============================================================================
//  Module      : cgra_load_buffer
//  Description : Simple dual-port RAM holding one job's load beats. One write
//                port, one read port with a registered (1-cycle) output that
//                resets to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cgra_load_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage array: written during FILL, no reset needed
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; holds the last entry read when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/cgra_host_sequencer.sv
// ============================================================================
//  Module      : cgra_host_sequencer
//  Description : Splits a QDMA job stream into a config/inbound table load
//                (start_loader + wr_data_ctrl_plane beats), a 4-phase
//                start/ready handshake, and a forwarded data stream.
//                Optional macro CGRA_SEQ_HS_TIMEOUT_EN adds a handshake
//                timeout with a DRAIN state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cgra_host_sequencer
    import cgra_seq_pkg::*;
#(
    parameter int phit_size    = 512,
    parameter int SIMD_degree  = 16,
    parameter int dwidth_RFadd = 5,
    parameter int LOAD_DEPTH   = 2**(dwidth_RFadd+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [phit_size-1:0]    s_tdata,
    input  logic [SIMD_degree-1:0]  s_tkeep,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    output logic                    start_loader,
    output logic [dwidth_RFadd-1:0] num_entry_config_table,
    output logic [dwidth_RFadd-1:0] num_entry_inbound,
    output logic [phit_size-1:0]    wr_data_ctrl_plane,
    output logic                    start_stream_in,
    input  logic                    ready_stream_in,
    output logic [phit_size-1:0]    stream_in,
    output logic [SIMD_degree-1:0]  t_stream_in_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int CW      = dwidth_RFadd + 1;
    localparam int AW      = $clog2(LOAD_DEPTH);
    localparam int CFG_LSB = HDR_CFG_FIELD * dwidth_RFadd;
    localparam int INB_LSB = HDR_INB_FIELD * dwidth_RFadd;

    seq_state_t             r_state;
    seq_state_t             w_next;
    logic [CW-1:0]          r_len;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_len_hdr;
    logic [dwidth_RFadd-1:0] r_num_cfg;
    logic [dwidth_RFadd-1:0] r_num_inb;
    logic [phit_size-1:0]   r_stream;
    logic [SIMD_degree-1:0] r_tvalid;
    logic                   r_out_en;
    logic                   r_err;
    logic                   w_tready;
    logic                   w_acc;
    logic                   w_hdr_ok;
    logic                   w_err_set;
    logic                   w_timeout;

    assign w_acc     = w_tready & s_tvalid;
    assign w_len_hdr = {1'b0, s_tdata[CFG_LSB +: dwidth_RFadd]}
                     + {1'b0, s_tdata[INB_LSB +: dwidth_RFadd]};
    assign w_hdr_ok  = (r_state == S_IDLE) && w_acc && !s_tlast;

`ifdef CGRA_SEQ_HS_TIMEOUT_EN
    logic [HS_TO_W-1:0] r_to_cnt;

    assign w_timeout = (r_state == S_HS) && !ready_stream_in
                    && (r_to_cnt == HS_TO_W'(HS_TIMEOUT - 1));

    // Count cycles spent waiting in HS; cleared in every other state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_state == S_HS) begin
            r_to_cnt <= r_to_cnt + HS_TO_W'(1);
        end else begin
            r_to_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and error-pulse decode
    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc && s_tlast) begin
                    w_err_set = 1'b1;
                end else if (w_acc) begin
                    w_next = (w_len_hdr == '0) ? S_HS : S_FILL;
                end
            end
            S_FILL: begin
                if (w_acc && s_tlast) begin
                    w_err_set = 1'b1;
                    w_next    = S_IDLE;
                end else if (w_acc && (r_cnt == r_len - CW'(1))) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_cnt == r_len) begin
                    w_next = S_HS;
                end
            end
            S_HS: begin
                if (ready_stream_in) begin
                    w_next = S_STREAM;
                end
`ifdef CGRA_SEQ_HS_TIMEOUT_EN
                else if (w_timeout) begin
                    w_err_set = 1'b1;
                    w_next    = S_DRAIN;
                end
`endif
            end
            S_STREAM: begin
                if (w_acc && s_tlast) begin
                    w_next = S_IDLE;
                end
            end
`ifdef CGRA_SEQ_HS_TIMEOUT_EN
            S_DRAIN: begin
                if (w_acc && s_tlast) begin
                    w_next = S_IDLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs; s_tready is held low until the first edge after reset
    always_comb begin
        w_tready        = 1'b0;
        start_stream_in = 1'b0;
        start_loader    = 1'b0;
        busy            = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:   w_tready = r_out_en && !ready_stream_in;
            S_FILL:   w_tready = 1'b1;
            S_LOAD:   start_loader = (r_cnt == '0);
            S_HS:     start_stream_in = 1'b1;
            S_STREAM: w_tready = 1'b1;
`ifdef CGRA_SEQ_HS_TIMEOUT_EN
            S_DRAIN:  w_tready = 1'b1;
`endif
            default:  w_tready = 1'b0;
        endcase
    end

    // Datapath: header latch, beat counter, stream forwarding, error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_en  <= 1'b0;
            r_err     <= 1'b0;
            r_num_cfg <= '0;
            r_num_inb <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_stream  <= '0;
            r_tvalid  <= '0;
        end else begin
            r_out_en <= 1'b1;
            r_err    <= w_err_set;
            if (w_hdr_ok) begin
                r_num_cfg <= s_tdata[CFG_LSB +: dwidth_RFadd];
                r_num_inb <= s_tdata[INB_LSB +: dwidth_RFadd];
                r_len     <= w_len_hdr;
            end
            if (r_state != w_next) begin
                r_cnt <= '0;
            end else if ((r_state == S_FILL && w_acc) || r_state == S_LOAD) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (r_state == S_STREAM && w_acc) begin
                r_stream <= s_tdata;
                r_tvalid <= s_tkeep;
            end else begin
                r_tvalid <= '0;
            end
        end
    end

    cgra_load_buffer #(
        .DEPTH (LOAD_DEPTH),
        .WIDTH (phit_size),
        .AW    (AW)
    ) u_load_buffer (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   ((r_state == S_FILL) && w_acc),
        .i_wr_addr (AW'(r_cnt)),
        .i_wr_data (s_tdata),
        .i_rd_en   ((r_state == S_LOAD) && (r_cnt != r_len)),
        .i_rd_addr (AW'(r_cnt)),
        .o_rd_data (wr_data_ctrl_plane)
    );

    assign s_tready               = w_tready;
    assign num_entry_config_table = r_num_cfg;
    assign num_entry_inbound      = r_num_inb;
    assign stream_in              = r_stream;
    assign t_stream_in_valid      = r_tvalid;
    assign err                    = r_err;

endmodule

`default_nettype wire
